// File: rtl/sgd_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sgd_dot_accumulator
// Description : Sums num_chunks saturating partial sums per sample and hands
//               each dot product out through a one-entry valid/ready register.
// Revision    : 1.0 - initial release
// ============================================================================
module sgd_dot_accumulator #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] num_chunks,
    input  logic signed [31:0]   v_input,
    input  logic                 v_input_valid,
    output logic signed [31:0]   v_output,
    output logic                 v_output_valid,
    input  logic                 v_output_ready,
    output logic                 busy,
    output logic                 err_drop
);

    localparam logic [31:0] C_SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] C_SAT_MIN = 32'h8000_0000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_WIDTH-1:0] r_num;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic signed [31:0]   r_acc;
    logic signed [31:0]   r_out;
    logic                 r_out_valid;
    logic                 r_err_drop;

    logic [32:0] w_wide;
    logic [31:0] w_sat;
    logic        w_start_ok;
    logic        w_stop_run;
    logic        w_beat;
    logic        w_last;
    logic        w_accept;
    logic        w_load;
    logic        w_drop;

    // stop has priority over start and over any beat arriving with it
    assign w_start_ok = (r_state == ST_IDLE) && start && !stop && (num_chunks != '0);
    assign w_stop_run = (r_state == ST_RUN) && stop;
    assign w_beat     = (r_state == ST_RUN) && v_input_valid && !stop;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_last     = w_beat && (w_cnt_inc == r_num);

    assign w_wide = {r_acc[31], r_acc} + {v_input[31], v_input};
    always_comb begin
        w_sat = w_wide[31:0];
        if (w_wide[32] != w_wide[31]) begin
            w_sat = w_wide[32] ? C_SAT_MIN : C_SAT_MAX;
        end
    end

    assign w_accept = r_out_valid && v_output_ready;
    assign w_load   = w_last && (!r_out_valid || v_output_ready);
    assign w_drop   = w_last && r_out_valid && !v_output_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_next = ST_RUN;
            ST_RUN:  if (stop)       w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num <= '0;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_start_ok) begin
            r_num <= num_chunks;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_stop_run || w_last) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_beat) begin
            r_cnt <= w_cnt_inc;
            r_acc <= w_sat;
        end
    end

    // Output register: a new result may replace one being accepted on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err_drop  <= 1'b0;
        end else begin
            if (w_load) begin
                r_out       <= w_sat;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out       <= '0;
                r_out_valid <= 1'b0;
            end
            if (w_drop) begin
                r_err_drop <= 1'b1;
            end
        end
    end

    assign v_output       = r_out;
    assign v_output_valid = r_out_valid;
    assign busy           = (r_state == ST_RUN);
    assign err_drop       = r_err_drop;

endmodule
`default_nettype wire
